// File: rtl/kasumi_ex_pkg.sv
// Shared encodings for the execute stage: command classes, M-extension funct3,
// funct7 patterns and the multi-cycle FSM states.
package kasumi_ex_pkg;

  localparam logic [2:0] EX_IMM   = 3'b000;
  localparam logic [2:0] EX_REG   = 3'b001;
  localparam logic [2:0] EX_BR    = 3'b010;
  localparam logic [2:0] EX_M     = 3'b011;
  localparam logic [2:0] EX_JMP   = 3'b100;
  localparam logic [2:0] EX_CSR   = 3'b101;
  localparam logic [2:0] EX_FENCE = 3'b110;

  localparam logic [2:0] M_MUL    = 3'd0;
  localparam logic [2:0] M_MULH   = 3'd1;
  localparam logic [2:0] M_MULHSU = 3'd2;
  localparam logic [2:0] M_MULHU  = 3'd3;
  localparam logic [2:0] M_DIV    = 3'd4;
  localparam logic [2:0] M_DIVU   = 3'd5;
  localparam logic [2:0] M_REM    = 3'd6;
  localparam logic [2:0] M_REMU   = 3'd7;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_div_unit.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle.
module muldiv_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stop,
  input  logic            abort,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN:0]   shifted, trial;

  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // High while the final quotient bit is being produced.
  assign done      = (cnt_q == CntW'(1));
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (!stop) begin
      if (abort) begin
        cnt_q <= '0;
      end else if (start) begin
        cnt_q <= CntW'(XLEN);
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
      end else if (cnt_q != '0) begin
        rem_q <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Execute stage: single-cycle RV32I ops plus RV32M with a pipelined multiplier
// and an iterative divider, stalling upstream through busy.
module execute_muldiv
  import kasumi_ex_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stop,
  input  logic            bubble,
  input  logic [4:0]      in_reg_d,
  input  logic [4:0]      in_mem_command,
  input  logic [5:0]      ex_command,
  input  logic [6:0]      ex_command_f7,
  input  logic [XLEN-1:0] data_0,
  input  logic [XLEN-1:0] data_1,
  input  logic [XLEN-1:0] in_mem_write_data,
  input  logic [XLEN-1:0] in_now_pc,
  output logic            busy,
  output logic            if_bubble,
  output logic            id_bubble,
  output logic            wb_pc,
  output logic [XLEN-1:0] wb_pc_data,
  output logic [4:0]      out_mem_command,
  output logic [4:0]      out_reg_d,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] out_mem_write_data,
  output logic [XLEN-1:0] out_now_pc
);

  localparam int unsigned ShW      = $clog2(XLEN);
  localparam int unsigned PipeLast = (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;
  localparam logic [2:0]  MulLast  = 3'(MUL_LATENCY - 1);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]     ex_class, f3;
  logic [ShW-1:0] shamt;
  logic           is_m, is_mul, is_div, alt;

  assign ex_class = ex_command[5:3];
  assign f3       = ex_command[2:0];
  assign shamt    = data_1[ShW-1:0];
  assign is_m     = (ex_class == EX_M);
  assign is_mul   = is_m && !f3[2];
  assign is_div   = is_m && f3[2];
  assign alt      = (ex_command_f7 == F7_ALT);

  // Base integer ALU
  logic [XLEN-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (ex_class)
      EX_IMM, EX_REG: begin
        unique case (f3)
          3'b000: alu_res = (ex_class == EX_REG && alt) ? data_0 - data_1 : data_0 + data_1;
          3'b001: alu_res = data_0 << shamt;
          3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(data_0) < $signed(data_1)};
          3'b011: alu_res = {{(XLEN-1){1'b0}}, data_0 < data_1};
          3'b100: alu_res = data_0 ^ data_1;
          3'b101: alu_res = alt ? $unsigned($signed(data_0) >>> shamt) : data_0 >> shamt;
          3'b110: alu_res = data_0 | data_1;
          3'b111: alu_res = data_0 & data_1;
          default: alu_res = '0;
        endcase
      end
      EX_JMP:  alu_res = in_now_pc + XLEN'(4);
      EX_CSR:  alu_res = data_0;
      default: alu_res = '0;
    endcase
  end

  // Redirects are purely combinational from the presented instruction.
  logic taken, redirect;
  always_comb begin
    case (f3)
      3'b000:  taken = (data_0 == data_1);
      3'b001:  taken = (data_0 != data_1);
      3'b100:  taken = $signed(data_0) < $signed(data_1);
      3'b101:  taken = $signed(data_0) >= $signed(data_1);
      3'b110:  taken = data_0 < data_1;
      3'b111:  taken = data_0 >= data_1;
      default: taken = 1'b0;
    endcase
  end

  assign redirect   = !bubble && ((ex_class == EX_BR && taken) || ex_class == EX_JMP);
  assign wb_pc      = redirect;
  assign if_bubble  = redirect;
  assign id_bubble  = redirect;
  assign wb_pc_data = (ex_class == EX_JMP && f3[0]) ?
                      ((data_0 + in_mem_write_data) & ~XLEN'(1)) :
                      (in_now_pc + in_mem_write_data);

  // Multiplier: sign-extend to 2*XLEN so one unsigned multiply covers all variants.
  logic            mul_as, mul_bs;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0] mul_res;
  assign mul_as  = (f3 == M_MULH) || (f3 == M_MULHSU);
  assign mul_bs  = (f3 == M_MULH);
  assign mul_a   = {{XLEN{mul_as & data_0[XLEN-1]}}, data_0};
  assign mul_b   = {{XLEN{mul_bs & data_1[XLEN-1]}}, data_1};
  assign product = mul_a * mul_b;
  assign mul_res = (f3 == M_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

  // Divider operand preparation and single-cycle special cases
  logic            div_signed, a_neg, b_neg, div_zero, div_ovf, div_fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  assign div_signed = (f3 == M_DIV) || (f3 == M_REM);
  assign a_neg      = div_signed & data_0[XLEN-1];
  assign b_neg      = div_signed & data_1[XLEN-1];
  assign a_mag      = a_neg ? -data_0 : data_0;
  assign b_mag      = b_neg ? -data_1 : data_1;
  assign div_zero   = (data_1 == '0);
  assign div_ovf    = div_signed && (data_0 == MinInt) && (data_1 == '1);
  assign div_fast   = div_zero || div_ovf;
  assign fast_res   = f3[1] ? (div_zero ? data_0 : '0) : (div_zero ? '1 : MinInt);

  logic [1:0]      state_q, state_d;
  logic [2:0]      mul_cnt_q, mul_cnt_d;
  logic [XLEN-1:0] mul_pipe_q [MUL_LATENCY];
  logic            q_neg_q, r_neg_q, want_rem_q;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quo, div_rem, div_fixed, result;

  muldiv_div_unit #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .stop      (stop),
    .abort     (bubble),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_fixed = want_rem_q ? (r_neg_q ? -div_rem : div_rem) :
                                  (q_neg_q ? -div_quo : div_quo);

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    busy      = 1'b0;
    div_start = 1'b0;
    result    = alu_res;
    case (state_q)
      ST_IDLE: begin
        if (is_mul) begin
          if (MUL_LATENCY == 1) begin
            result = mul_res;
          end else begin
            busy      = 1'b1;
            state_d   = ST_MUL;
            mul_cnt_d = 3'd1;
          end
        end else if (is_div) begin
          if (div_fast) begin
            result = fast_res;
          end else begin
            busy      = 1'b1;
            div_start = 1'b1;
            state_d   = ST_DIV;
          end
        end
      end
      ST_MUL: begin
        if (mul_cnt_q == MulLast) begin
          result  = mul_pipe_q[PipeLast];
          state_d = ST_IDLE;
        end else begin
          busy      = 1'b1;
          mul_cnt_d = mul_cnt_q + 3'd1;
        end
      end
      ST_DIV: begin
        busy = 1'b1;
        if (div_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        result  = div_fixed;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bubble) begin
      state_d   = ST_IDLE;
      div_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      mul_cnt_q          <= '0;
      q_neg_q            <= 1'b0;
      r_neg_q            <= 1'b0;
      want_rem_q         <= 1'b0;
      out_reg_d          <= '0;
      out_mem_command    <= '0;
      alu_out            <= '0;
      out_mem_write_data <= '0;
      out_now_pc         <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) mul_pipe_q[i] <= '0;
    end else if (!stop) begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      mul_pipe_q[0] <= mul_res;
      for (int i = 1; i < MUL_LATENCY; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      if (div_start) begin
        q_neg_q    <= a_neg ^ b_neg;
        r_neg_q    <= a_neg;
        want_rem_q <= f3[1];
      end
      out_now_pc         <= in_now_pc;
      out_mem_write_data <= in_mem_write_data;
      // Stalled or squashed cycles retire a bubble so MEM/WB never see a repeat.
      if (busy || bubble) begin
        out_reg_d       <= '0;
        out_mem_command <= '0;
        alu_out         <= '0;
      end else begin
        out_reg_d       <= in_reg_d;
        out_mem_command <= in_mem_command;
        alu_out         <= result;
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: stimulus pushes expected retirements,
// an independent monitor pops them whenever a non-bubble result appears.
module tb_execute_muldiv;
  import kasumi_ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop = 1'b0;
  logic        bubble = 1'b0;
  logic [4:0]  in_reg_d = '0;
  logic [4:0]  in_mem_command = '0;
  logic [5:0]  ex_command = '0;
  logic [6:0]  ex_command_f7 = '0;
  logic [31:0] data_0 = '0, data_1 = '0, in_mem_write_data = '0, in_now_pc = '0;
  logic        busy, if_bubble, id_bubble, wb_pc;
  logic [31:0] wb_pc_data, alu_out, out_mem_write_data, out_now_pc;
  logic [4:0]  out_mem_command, out_reg_d;

  execute_muldiv #(
    .XLEN        (32),
    .MUL_LATENCY (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stop               (stop),
    .bubble             (bubble),
    .in_reg_d           (in_reg_d),
    .in_mem_command     (in_mem_command),
    .ex_command         (ex_command),
    .ex_command_f7      (ex_command_f7),
    .data_0             (data_0),
    .data_1             (data_1),
    .in_mem_write_data  (in_mem_write_data),
    .in_now_pc          (in_now_pc),
    .busy               (busy),
    .if_bubble          (if_bubble),
    .id_bubble          (id_bubble),
    .wb_pc              (wb_pc),
    .wb_pc_data         (wb_pc_data),
    .out_mem_command    (out_mem_command),
    .out_reg_d          (out_reg_d),
    .alu_out            (alu_out),
    .out_mem_write_data (out_mem_write_data),
    .out_now_pc         (out_now_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  rd;
    logic [31:0] alu;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_stop;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [2:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] mwd);
    ex_command        = {cls, f3};
    ex_command_f7     = f7;
    data_0            = d0;
    data_1            = d1;
    in_reg_d          = rd;
    in_now_pc         = pc;
    in_mem_write_data = mwd;
    in_mem_command    = '0;
  endtask

  task automatic nop();
    drive(EX_IMM, 3'd0, F7_BASE, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
  endtask

  // Counts cycles with busy high; optionally holds stop for stop_len cycles.
  task automatic wait_idle(input string name, input int exp_n, input int stop_at,
                           input int stop_len);
    int n = 0;
    #1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      if (stop_len != 0 && n == stop_at) stop = 1'b1;
      if (stop_len != 0 && n == stop_at + stop_len) stop = 1'b0;
      #1;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic op(input string name, input logic [2:0] cls, input logic [2:0] f3,
                    input logic [6:0] f7, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [4:0] rd, input logic [31:0] exp_alu, input int exp_busy,
                    input int stop_at = 0, input int stop_len = 0);
    exp_t e;
    @(negedge clk);
    drive(cls, f3, f7, d0, d1, rd, 32'h1000, 32'h0);
    e.name = name;
    e.rd   = rd;
    e.alu  = exp_alu;
    exp_q.push_back(e);
    wait_idle(name, exp_busy, stop_at, stop_len);
  endtask

  always @(posedge clk) begin
    mon_stop = stop;
    #1;
    if (rst_n && !mon_stop && out_reg_d != 5'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire: got rd=%0d alu=0x%0h, required no retirement",
                 out_reg_d, alu_out);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_rd"}, 64'(out_reg_d), 64'(mon_e.rd));
        check(mon_e.name, 64'(alu_out), 64'(mon_e.alu));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_alu_out", 64'(alu_out), 64'd0);
    check("reset_reg_d", 64'(out_reg_d), 64'd0);
    check("reset_now_pc", 64'(out_now_pc), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op("addi", EX_IMM, 3'd0, F7_BASE, 32'd5, 32'd7, 5'd1, 32'd12, 0);
    op("sub", EX_REG, 3'd0, F7_ALT, 32'd10, 32'd3, 5'd2, 32'd7, 0);
    op("sra", EX_REG, 3'd5, F7_ALT, 32'h8000_0000, 32'd4, 5'd3, 32'hF800_0000, 0);

    // jal: link value retires, redirect target is pc + offset
    @(negedge clk);
    drive(EX_JMP, 3'd0, F7_BASE, 32'd0, 32'd0, 5'd4, 32'h200, 32'h10);
    exp_q.push_back('{name: "jal", rd: 5'd4, alu: 32'h204});
    #1;
    check("jal_wb_pc", 64'(wb_pc), 64'd1);
    check("jal_wb_pc_data", 64'(wb_pc_data), 64'h210);
    wait_idle("jal", 0, 0, 0);

    op("div_100_7", EX_M, M_DIV, F7_MULDIV, 32'd100, 32'd7, 5'd5, 32'd14, 33);
    op("rem_100_7", EX_M, M_REM, F7_MULDIV, 32'd100, 32'd7, 5'd6, 32'd2, 33);
    op("div_ovf", EX_M, M_DIV, F7_MULDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,
       32'h8000_0000, 0);
    op("rem_ovf", EX_M, M_REM, F7_MULDIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 0);
    op("divu_zero", EX_M, M_DIVU, F7_MULDIV, 32'd123, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
    op("remu_zero", EX_M, M_REMU, F7_MULDIV, 32'd9, 32'd0, 5'd10, 32'd9, 0);
    op("mulh_m1", EX_M, M_MULH, F7_MULDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0, 1);
    op("mulhu_m1", EX_M, M_MULHU, F7_MULDIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12,
       32'hFFFF_FFFE, 1);
    op("mul_7_m3", EX_M, M_MUL, F7_MULDIV, 32'd7, 32'hFFFF_FFFD, 5'd13, 32'hFFFF_FFEB, 1);
    op("div_neg", EX_M, M_DIV, F7_MULDIV, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFF2, 33);
    op("rem_neg", EX_M, M_REM, F7_MULDIV, 32'hFFFF_FF9C, 32'd7, 5'd15, 32'hFFFF_FFFE, 33);
    op("div_stop", EX_M, M_DIV, F7_MULDIV, 32'd100, 32'd7, 5'd16, 32'd14, 38, 10, 5);

    // bubble mid-divide: the op is squashed and never retires
    @(negedge clk);
    drive(EX_M, M_DIV, F7_MULDIV, 32'd100, 32'd7, 5'd20, 32'h1000, 32'h0);
    repeat (10) @(negedge clk);
    bubble = 1'b1;
    #1;
    check("bubble_cycle_busy", 64'(busy), 64'd1);
    @(negedge clk);
    bubble = 1'b0;
    nop();
    #1;
    check("bubble_after_busy", 64'(busy), 64'd0);
    check("bubble_after_reg_d", 64'(out_reg_d), 64'd0);

    // bgeu: unsigned compare, taken and not taken
    @(negedge clk);
    drive(EX_BR, 3'b111, F7_BASE, 32'h8000_0000, 32'd1, 5'd0, 32'h100, 32'h40);
    #1;
    check("bgeu_taken_wb_pc", 64'(wb_pc), 64'd1);
    check("bgeu_taken_if_bubble", 64'(if_bubble), 64'd1);
    check("bgeu_taken_target", 64'(wb_pc_data), 64'h140);
    @(negedge clk);
    drive(EX_BR, 3'b111, F7_BASE, 32'd1, 32'h8000_0000, 5'd0, 32'h100, 32'h40);
    #1;
    check("bgeu_not_taken_wb_pc", 64'(wb_pc), 64'd0);

    // reset asserted mid-divide
    @(negedge clk);
    drive(EX_M, M_DIV, F7_MULDIV, 32'd100, 32'd7, 5'd21, 32'h300, 32'h0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    nop();
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_alu_out", 64'(alu_out), 64'd0);
    check("midreset_reg_d", 64'(out_reg_d), 64'd0);
    check("midreset_mem_cmd", 64'(out_mem_command), 64'd0);
    check("midreset_now_pc", 64'(out_now_pc), 64'd0);
    check("midreset_wdata", 64'(out_mem_write_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op("add_after_reset", EX_IMM, 3'd0, F7_BASE, 32'd1, 32'd1, 5'd17, 32'd2, 0);

    @(negedge clk);
    nop();
    repeat (3) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Parametrised successor to the single-cycle RV32I execute stage. Sits between decode and memory stages.
- Adds the RV32M command class (ex_command[5:3]=011) with a pipelined multiplier and an iterative radix-2 divider.
- A busy handshake stalls upstream stages while a multi-cycle op runs. Also adds asynchronous reset and an XLEN parameter.

Parameters:
- XLEN, 32: datapath width. Must be 32 or 64.
- MUL_LATENCY, 2: cycles from mul-class op presentation to result latch. Range 1..4.

Ports:
- clk  in  1  stage clock
- rst_n  in  1  asynchronous active-low reset
- stop  in  1  freeze all state, including the divider/multiplier FSM
- bubble  in  1  insert bubble; aborts any in-flight M op
- in_reg_d  in  5  destination register
- in_mem_command  in  5  [0] mem access, [1] write, [4:2] funct3
- ex_command  in  6  [5:3] class (000 imm, 001 reg, 010 branch, 011 M, 100 jal/jalr, 101 csr, 110 fence), [2:0] funct3
- ex_command_f7  in  7  funct7
- data_0, data_1  in  XLEN  operands
- in_mem_write_data  in  XLEN  store data / branch offset
- in_now_pc  in  XLEN  instruction PC
- busy  out  1  combinational; upstream must hold all inputs stable while high
- if_bubble, id_bubble, wb_pc  out  1  redirect flush/request
- wb_pc_data  out  XLEN  redirect target
- out_mem_command  out  5  registered
- out_reg_d  out  5  registered
- alu_out, out_mem_write_data, out_now_pc  out  XLEN  registered

Behaviour:
- Reset: all registered outputs are 0; FSM goes to IDLE; multiplier pipe is cleared.
- Non-M classes: identical single-cycle semantics to the existing stage, 1-cycle latency.
  - Branch funct3 111 = bgeu (unsigned >=).
  - Shifts use data_1[log2(XLEN)-1:0].
  - jal/jalr: alu_out = pc+4.
- M funct3 mapping: 0 mul (low XLEN bits), 1 mulh (s×s), 2 mulhsu (s×u), 3 mulhu (u×u), 4 div, 5 divu, 6 rem, 7 remu.
- FSM states: IDLE, MUL, DIV, DONE.
- MUL path:
  - Op presented in cycle 0 while in IDLE.
  - If MUL_LATENCY=1: result latched at end of cycle 0; busy never asserts.
  - Otherwise: busy=1 in cycles 0..MUL_LATENCY-2; result latched at end of cycle MUL_LATENCY-1, with busy=0 in that cycle.
- DIV path:
  - Operands are captured at end of cycle 0; a counter is loaded with XLEN.
  - One quotient bit per cycle in cycles 1..XLEN.
  - DONE is cycle XLEN+1: busy=0 and the result is latched.
  - busy=1 in cycles 0..XLEN.
  - Signed ops: operate on magnitudes, then fix signs. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- DIV fast paths: resolved in cycle 0, busy never asserts.
  - Divisor 0: quotient = all-ones; remainder = dividend.
  - Signed overflow (min_int / −1): quotient = min_int; remainder = 0.
- Output register while busy=1: loads a bubble each cycle (reg_d=0, mem_command=0, alu_out=0, out_now_pc=in_now_pc). MEM/WB therefore never see duplicate writes.
- stop=1: every register holds, including the FSM, counter and partial remainder/quotient. busy keeps its value.
- bubble=1 (with stop=0): FSM forced to IDLE, partial results discarded, output loads a bubble. bubble takes priority over DONE in the same cycle.
- Same-cycle arrival: a new M op can be accepted in the cycle after DONE; there is no dead cycle.
- rst_n deassertion mid-operation: restart from IDLE; the op is lost, since upstream is reset too.
- Redirect outputs (wb_pc etc.) are combinational from the current inputs. M ops never redirect.

Decomposition:
- Package kasumi_ex_pkg holds:
  - ex-class constants (EX_IMM, EX_REG, EX_BR, EX_M, EX_JMP, EX_CSR, EX_FENCE);
  - M funct3 constants;
  - FSM state enum;
  - funct7 constants 0000000 / 0100000 / 0000001.
- One sub-module, muldiv_div_unit: iterative restoring divider with start/done, stop-hold and abort inputs.
- The multiplier is a MUL_LATENCY-deep register pipe inside the top module.

Test Plan:
- div x, data_0=100, data_1=7, XLEN=32 → busy high exactly 33 cycles; alu_out=14 on the next edge. Same operands with rem → 2.
- div, data_0=0x80000000, data_1=0xFFFFFFFF → busy never asserts; alu_out=0x80000000. rem of the same operands → 0.
- divu, data_1=0 → alu_out=0xFFFFFFFF, busy=0. remu of 9 by 0 → 9.
- mulh, data_0=0xFFFFFFFF, data_1=0xFFFFFFFF, MUL_LATENCY=2 → busy 1 cycle; alu_out=0. mulhu of the same → 0xFFFFFFFE.
- div in flight: stop pulsed 5 cycles mid-way → completion delayed by exactly 5 cycles with correct result. bubble mid-way → busy drops next cycle; out_reg_d=0.
- bgeu, data_0=0x80000000, data_1=1 → wb_pc=1, wb_pc_data=pc+offset. rst_n low mid-div → all outputs 0, busy=0.
